// File: rtl/mand_sched.sv
// Mandelbrot iteration scheduler: streams point indices, tracks escapes, ping-pongs banks.
// Result stage LATENCY cycles after issue; no datapath backpressure, bus acks one cycle after request.
module mand_sched #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 30,
  parameter int ITER_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic              we_i,
  input  logic [1:0]        adr_i,
  input  logic [31:0]       dat_i,
  output logic [31:0]       dat_o,
  output logic              ack_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_adr_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_adr_o,
  input  logic              esc_i,
  output logic              buf_sel_o,
  output logic              cnt_we_o,
  output logic [ADDR_W-1:0] cnt_adr_o,
  output logic [ITER_W-1:0] cnt_dat_o,
  output logic              busy_o
);

  localparam int NPTS_W = ADDR_W + 1;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, SWAP} state_t;

  state_t              state_q, state_d;
  logic                ack_q, ack_d;
  logic [31:0]         dat_q, dat_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_adr_q, rd_adr_d;
  logic                buf_sel_q, buf_sel_d;
  logic                cnt_we_q, cnt_we_d;
  logic [ADDR_W-1:0]   cnt_adr_q, cnt_adr_d;
  logic [ITER_W-1:0]   cnt_dat_q, cnt_dat_d;
  logic                busy_q, busy_d;
  logic [NPTS_W-1:0]   npts_q, npts_d;
  logic [ITER_W-1:0]   max_iter_q, max_iter_d;
  logic [ITER_W-1:0]   pass_q, pass_d;
  logic [NPTS_W-1:0]   esc_cnt_q, esc_cnt_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;
  logic [DEPTH-1:0]    esc_map_q, esc_map_d;
  logic [LATENCY-1:0]  vld_q, vld_d;
  logic [ADDR_W-1:0]   padr_q [LATENCY];
  logic [ADDR_W-1:0]   padr_d [LATENCY];

  logic                req, wr_req, start_cmd, abort_cmd;
  logic                out_vld;
  logic [ADDR_W-1:0]   out_adr;
  logic [ITER_W-1:0]   pass_inc;
  logic                last_pass;
  logic                unused_dat;

  assign req       = cyc_i & stb_i & ~ack_q;
  assign wr_req    = req & we_i;
  assign abort_cmd = wr_req & (adr_i == 2'd0) & dat_i[1];
  assign start_cmd = wr_req & (adr_i == 2'd0) & dat_i[0] & ~dat_i[1];
  assign out_vld   = vld_q[LATENCY-1];
  assign out_adr   = padr_q[LATENCY-1];
  assign pass_inc  = (pass_q == '1) ? pass_q : pass_q + ITER_W'(1);
  assign last_pass = ({1'b0, pass_q} + (ITER_W+1)'(1)) == {1'b0, max_iter_q};
  assign unused_dat = ^dat_i[31:ITER_W];

  always_comb begin
    state_d    = state_q;
    ack_d      = 1'b0;
    dat_d      = '0;
    rd_en_d    = rd_en_q;
    rd_adr_d   = rd_adr_q;
    buf_sel_d  = buf_sel_q;
    cnt_we_d   = 1'b0;
    cnt_adr_d  = cnt_adr_q;
    cnt_dat_d  = cnt_dat_q;
    busy_d     = busy_q;
    npts_d     = npts_q;
    max_iter_d = max_iter_q;
    pass_d     = pass_q;
    esc_cnt_d  = esc_cnt_q;
    done_d     = done_q;
    aborted_d  = aborted_q;
    esc_map_d  = esc_map_q;

    if (req) begin
      ack_d = 1'b1;
      if (!we_i) begin
        case (adr_i)
          2'd0: dat_d = {29'b0, aborted_q, done_q, busy_q};
          2'd1: dat_d = 32'(npts_q);
          2'd2: dat_d = 32'(max_iter_q);
          2'd3: dat_d = {16'(esc_cnt_q), 16'(pass_q)};
        endcase
      end
    end
    if (wr_req && !busy_q) begin
      if (adr_i == 2'd1) npts_d = dat_i[ADDR_W] ? NPTS_W'(DEPTH) : dat_i[NPTS_W-1:0];
      if (adr_i == 2'd2) max_iter_d = dat_i[ITER_W-1:0];
    end

    vld_d     = {vld_q[LATENCY-2:0], rd_en_q};
    padr_d[0] = rd_adr_q;
    for (int k = 1; k < LATENCY; k++) padr_d[k] = padr_q[k-1];

    // First escape of a point is recorded once; later esc_i for it is ignored.
    if (out_vld && esc_i && !esc_map_q[out_adr]) begin
      esc_map_d[out_adr] = 1'b1;
      esc_cnt_d          = esc_cnt_q + NPTS_W'(1);
      cnt_we_d           = 1'b1;
      cnt_adr_d          = out_adr;
      cnt_dat_d          = pass_inc;
    end

    case (state_q)
      IDLE: begin
        if (start_cmd) begin
          if (npts_q == '0 || max_iter_q == '0) begin
            done_d = 1'b1;
            pass_d = '0;
          end else begin
            esc_map_d = '0;
            esc_cnt_d = '0;
            pass_d    = '0;
            done_d    = 1'b0;
            aborted_d = 1'b0;
            buf_sel_d = 1'b0;
            busy_d    = 1'b1;
            rd_en_d   = 1'b1;
            rd_adr_d  = '0;
            state_d   = ISSUE;
          end
        end
      end
      ISSUE: begin
        if ({1'b0, rd_adr_q} == npts_q - NPTS_W'(1)) begin
          rd_en_d = 1'b0;
          state_d = DRAIN;
        end else begin
          rd_adr_d = rd_adr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (vld_q == '0) state_d = SWAP;
      end
      SWAP: begin
        pass_d    = pass_inc;
        buf_sel_d = ~buf_sel_q;
        if (last_pass || esc_cnt_q == npts_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          rd_en_d  = 1'b1;
          rd_adr_d = '0;
          state_d  = ISSUE;
        end
      end
    endcase

    // Abort drops everything in flight but leaves the progress counters readable.
    if (abort_cmd && busy_q) begin
      state_d   = IDLE;
      busy_d    = 1'b0;
      rd_en_d   = 1'b0;
      vld_d     = '0;
      aborted_d = 1'b1;
      done_d    = done_q;
      pass_d    = pass_q;
      buf_sel_d = buf_sel_q;
      esc_map_d = esc_map_q;
      esc_cnt_d = esc_cnt_q;
      cnt_we_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      rd_en_q    <= 1'b0;
      rd_adr_q   <= '0;
      buf_sel_q  <= 1'b0;
      cnt_we_q   <= 1'b0;
      cnt_adr_q  <= '0;
      cnt_dat_q  <= '0;
      busy_q     <= 1'b0;
      npts_q     <= '0;
      max_iter_q <= '0;
      pass_q     <= '0;
      esc_cnt_q  <= '0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      esc_map_q  <= '0;
      vld_q      <= '0;
      for (int k = 0; k < LATENCY; k++) padr_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      rd_en_q    <= rd_en_d;
      rd_adr_q   <= rd_adr_d;
      buf_sel_q  <= buf_sel_d;
      cnt_we_q   <= cnt_we_d;
      cnt_adr_q  <= cnt_adr_d;
      cnt_dat_q  <= cnt_dat_d;
      busy_q     <= busy_d;
      npts_q     <= npts_d;
      max_iter_q <= max_iter_d;
      pass_q     <= pass_d;
      esc_cnt_q  <= esc_cnt_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      esc_map_q  <= esc_map_d;
      vld_q      <= vld_d;
      padr_q     <= padr_d;
    end
  end

  assign ack_o     = ack_q;
  assign dat_o     = dat_q;
  assign rd_en_o   = rd_en_q;
  assign rd_adr_o  = rd_adr_q;
  assign wr_en_o   = out_vld & ~esc_map_q[out_adr];
  assign wr_adr_o  = out_adr;
  assign buf_sel_o = buf_sel_q;
  assign cnt_we_o  = cnt_we_q;
  assign cnt_adr_o = cnt_adr_q;
  assign cnt_dat_o = cnt_dat_q;
  assign busy_o    = busy_q;

endmodule
